// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: direction FSM states and the body controller state.
package snake_pkg;

   localparam logic [2:0] DIR_START = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;
   localparam logic [2:0] DIR_OVER  = 3'd5;

   typedef enum logic [2:0] {
      StIdle,
      StMove,
      StScan,
      StCommit,
      StDead
   } state_e;

   function automatic logic is_move_dir(input logic [2:0] d);
      return (d >= DIR_UP) && (d <= DIR_RIGHT);
   endfunction

endpackage

// File: rtl/snake_seg_store.sv
// Snake segment register array: parallel shift-in at the head, reset image, scan and render reads.
module snake_seg_store
   import snake_pkg::*;
#(
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int XW       = 5,
   parameter int YW       = 5,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3,
   parameter int IW       = $clog2(MAX_LEN)
) (
   input  logic          clkFSM,
   input  logic          reset,
   input  logic          shift,
   input  logic [XW-1:0] in_x,
   input  logic [YW-1:0] in_y,
   input  logic [IW-1:0] scan_idx,
   output logic [XW-1:0] scan_x,
   output logic [YW-1:0] scan_y,
   input  logic [IW-1:0] rd_idx,
   output logic [XW-1:0] rd_x,
   output logic [YW-1:0] rd_y,
   output logic [XW-1:0] head_x,
   output logic [YW-1:0] head_y
);

   logic [XW-1:0] seg_x [MAX_LEN];
   logic [YW-1:0] seg_y [MAX_LEN];

   always_ff @(posedge clkFSM) begin
      if (reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
            seg_y[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
         end
      end else if (shift) begin
         for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
         end
         seg_x[0] <= in_x;
         seg_y[0] <= in_y;
      end
   end

   assign scan_x = seg_x[scan_idx];
   assign scan_y = seg_y[scan_idx];
   assign rd_x   = seg_x[rd_idx];
   assign rd_y   = seg_y[rd_idx];
   assign head_x = seg_x[0];
   assign head_y = seg_y[0];

endmodule

// File: rtl/snake_body_ctrl.sv
// Per-tick snake body sequencer: move, serial self-collision scan, commit, sticky game-over.
// Define SNAKE_WRAP_EN to make the walls wrap instead of ending the game.
module snake_body_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int XW       = 5,
   parameter int YW       = 5,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3
) (
   input  logic                         clkFSM,
   input  logic                         reset,
   input  logic                         tick,
   input  logic [2:0]                   dir,
   input  logic [XW-1:0]                food_x,
   input  logic [YW-1:0]                food_y,
   input  logic                         food_valid,
   input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
   output logic [XW-1:0]                rd_x,
   output logic [YW-1:0]                rd_y,
   output logic                         rd_valid,
   output logic [XW-1:0]                head_x,
   output logic [YW-1:0]                head_y,
   output logic [$clog2(MAX_LEN+1)-1:0] length,
   output logic                         busy,
   output logic                         eat,
   output logic                         step_done,
   output logic                         over
);

   localparam int IW = $clog2(MAX_LEN);
   localparam int LW = $clog2(MAX_LEN + 1);

   state_e        state;
   logic [XW-1:0] nh_x, mv_x, scan_x, rd_x_c;
   logic [YW-1:0] nh_y, mv_y, scan_y, rd_y_c;
   logic [IW-1:0] k;
   logic [LW-1:0] limit;
   logic          grow, wall, wall_dead, scan_hit;

   snake_seg_store #(
      .GRID_W   (GRID_W),
      .GRID_H   (GRID_H),
      .XW       (XW),
      .YW       (YW),
      .MAX_LEN  (MAX_LEN),
      .INIT_LEN (INIT_LEN),
      .IW       (IW)
   ) u_store (
      .clkFSM   (clkFSM),
      .reset    (reset),
      .shift    (state == StCommit),
      .in_x     (nh_x),
      .in_y     (nh_y),
      .scan_idx (k),
      .scan_x   (scan_x),
      .scan_y   (scan_y),
      .rd_idx   (rd_idx),
      .rd_x     (rd_x_c),
      .rd_y     (rd_y_c),
      .head_x   (head_x),
      .head_y   (head_y)
   );

   // Candidate head with wrap-around; wall flags the crossing so the no-wrap build can kill.
   always_comb begin
      mv_x = head_x;
      mv_y = head_y;
      wall = 1'b0;
      case (dir)
         DIR_UP: begin
            wall = (head_y == '0);
            mv_y = wall ? YW'(GRID_H - 1) : head_y - YW'(1);
         end
         DIR_DOWN: begin
            wall = (head_y == YW'(GRID_H - 1));
            mv_y = wall ? '0 : head_y + YW'(1);
         end
         DIR_LEFT: begin
            wall = (head_x == '0);
            mv_x = wall ? XW'(GRID_W - 1) : head_x - XW'(1);
         end
         DIR_RIGHT: begin
            wall = (head_x == XW'(GRID_W - 1));
            mv_x = wall ? '0 : head_x + XW'(1);
         end
         default: ;
      endcase
   end

`ifdef SNAKE_WRAP_EN
   assign wall_dead = 1'b0;
`else
   assign wall_dead = wall;
`endif

   // The tail only vacates its cell when the snake does not grow.
   assign limit    = grow ? length - LW'(1) : length - LW'(2);
   assign scan_hit = (scan_x == nh_x) && (scan_y == nh_y);
   assign busy     = (state == StMove) || (state == StScan) || (state == StCommit);

   always_ff @(posedge clkFSM) begin
      if (reset) begin
         state     <= StIdle;
         nh_x      <= '0;
         nh_y      <= '0;
         grow      <= 1'b0;
         k         <= '0;
         length    <= LW'(INIT_LEN);
         over      <= 1'b0;
         eat       <= 1'b0;
         step_done <= 1'b0;
         rd_x      <= '0;
         rd_y      <= '0;
         rd_valid  <= 1'b0;
      end else begin
         eat       <= 1'b0;
         step_done <= 1'b0;
         rd_x      <= rd_x_c;
         rd_y      <= rd_y_c;
         rd_valid  <= LW'(rd_idx) < length;
         case (state)
            StIdle: begin
               if (tick) begin
                  if (is_move_dir(dir)) begin
                     state <= StMove;
                  end else if (dir == DIR_OVER) begin
                     state     <= StDead;
                     over      <= 1'b1;
                     step_done <= 1'b1;
                  end else begin
                     step_done <= 1'b1;
                  end
               end
            end
            StMove: begin
               k    <= '0;
               nh_x <= mv_x;
               nh_y <= mv_y;
               grow <= food_valid && (mv_x == food_x) && (mv_y == food_y);
               if (!is_move_dir(dir)) begin
                  state     <= StIdle;
                  step_done <= 1'b1;
               end else if (wall_dead) begin
                  state     <= StDead;
                  over      <= 1'b1;
                  step_done <= 1'b1;
               end else begin
                  state <= StScan;
               end
            end
            StScan: begin
               if (scan_hit) begin
                  state     <= StDead;
                  over      <= 1'b1;
                  step_done <= 1'b1;
               end else if (LW'(k) == limit) begin
                  state <= StCommit;
               end else begin
                  k <= k + IW'(1);
               end
            end
            StCommit: begin
               if (grow && (length < LW'(MAX_LEN))) length <= length + LW'(1);
               eat       <= grow;
               step_done <= 1'b1;
               state     <= StIdle;
            end
            StDead: ;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl; honours SNAKE_WRAP_EN for the wall scenario.
module tb_snake_body_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic [2:0] dir = 3'd0;
   logic [4:0] food_x = '0;
   logic [4:0] food_y = '0;
   logic       food_valid = 1'b0;
   logic [3:0] rd_idx = '0;
   logic [4:0] rd_x, rd_y, head_x, head_y, length;
   logic       rd_valid, busy, eat, step_done, over;

   int errors = 0;
   int checks = 0;

   snake_body_ctrl dut (
      .clkFSM     (clk),
      .reset      (reset),
      .tick       (tick),
      .dir        (dir),
      .food_x     (food_x),
      .food_y     (food_y),
      .food_valid (food_valid),
      .rd_idx     (rd_idx),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_valid   (rd_valid),
      .head_x     (head_x),
      .head_y     (head_y),
      .length     (length),
      .busy       (busy),
      .eat        (eat),
      .step_done  (step_done),
      .over       (over)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench one cycle after the tick edge, i.e. with the DUT in MOVE.
   task automatic do_tick(input logic [2:0] d, input logic fv, input int fx, input int fy);
      dir = d; food_valid = fv; food_x = 5'(fx); food_y = 5'(fy);
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!step_done && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (step_done !== 1'b1) begin
         errors++;
         $display("FAIL %s: step_done timeout got %b want 1", name, step_done);
      end
   endtask

   task automatic check_head(input string name, input int x, input int y, input int len);
      checks++;
      if (head_x !== 5'(x) || head_y !== 5'(y) || length !== 5'(len)) begin
         errors++;
         $display("FAIL %s: head=(%0d,%0d) len=%0d want (%0d,%0d) len=%0d",
                  name, head_x, head_y, length, x, y, len);
      end
   endtask

   task automatic check_rd(input string name, input int idx, input int x, input int y,
                           input logic v);
      rd_idx = 4'(idx);
      step();
      checks++;
      if (rd_valid !== v || (v && (rd_x !== 5'(x) || rd_y !== 5'(y)))) begin
         errors++;
         $display("FAIL %s: rd[%0d]=(%0d,%0d) v=%b want (%0d,%0d) v=%b",
                  name, idx, rd_x, rd_y, rd_valid, x, y, v);
      end
   endtask

   task automatic do_reset();
      tick = 1'b0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (over !== 1'b0 || busy !== 1'b0 || eat !== 1'b0 || step_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: over=%b busy=%b eat=%b done=%b want 0000",
                  over, busy, eat, step_done);
      end
      check_head("reset_head", 16, 12, 3);
      check_rd("reset_rd0", 0, 16, 12, 1'b1);
      check_rd("reset_rd1", 1, 15, 12, 1'b1);
      check_rd("reset_rd2", 2, 14, 12, 1'b1);
      check_rd("reset_rd3", 3, 0, 0, 1'b0);
   endtask

   task automatic test_move();
      do_tick(3'd4, 1'b0, 0, 0);
      step(3);
      checks++;
      if (busy !== 1'b1 || step_done !== 1'b0) begin
         errors++;
         $display("FAIL move_commit: busy=%b done=%b want 1 0", busy, step_done);
      end
      step();
      checks++;
      if (step_done !== 1'b1 || eat !== 1'b0) begin
         errors++;
         $display("FAIL move_done: done=%b eat=%b want 1 0", step_done, eat);
      end
      check_head("move_head", 17, 12, 3);
      check_rd("move_tail", 2, 15, 12, 1'b1);
   endtask

   task automatic test_grow();
      do_tick(3'd4, 1'b1, 18, 12);
      step(4);
      checks++;
      if (busy !== 1'b1 || step_done !== 1'b0) begin
         errors++;
         $display("FAIL grow_scan_len: busy=%b done=%b want 1 0", busy, step_done);
      end
      step();
      checks++;
      if (eat !== 1'b1 || step_done !== 1'b1) begin
         errors++;
         $display("FAIL grow_eat: eat=%b done=%b want 1 1", eat, step_done);
      end
      check_head("grow_head", 18, 12, 4);
      step();
      checks++;
      if (eat !== 1'b0) begin
         errors++;
         $display("FAIL grow_eat_pulse: eat=%b want 0", eat);
      end
      check_rd("grow_seg3", 3, 15, 12, 1'b1);
      check_rd("grow_seg4", 4, 0, 0, 1'b0);
   endtask

   task automatic test_collision();
      int n = 0;
      int extra = 0;
      do_tick(3'd4, 1'b1, 19, 12);
      wait_done("coll_grow");
      check_head("coll_len5", 19, 12, 5);
      do_tick(3'd1, 1'b0, 0, 0);
      wait_done("coll_up");
      do_tick(3'd3, 1'b0, 0, 0);
      wait_done("coll_left");
      check_head("coll_left_head", 18, 11, 5);
      do_tick(3'd2, 1'b0, 0, 0);
      while (!over && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (over !== 1'b1 || step_done !== 1'b1) begin
         errors++;
         $display("FAIL coll_over: over=%b done=%b want 1 1", over, step_done);
      end
      check_head("coll_no_shift", 18, 11, 5);
      do_tick(3'd4, 1'b0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (step_done) extra++;
         step();
      end
      checks++;
      if (extra !== 0 || over !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL coll_ignore: done_pulses=%0d over=%b busy=%b want 0 1 0",
                  extra, over, busy);
      end
      check_head("coll_dead_head", 18, 11, 5);
      do_reset();
      checks++;
      if (over !== 1'b0) begin
         errors++;
         $display("FAIL coll_reset_over: over=%b want 0", over);
      end
      check_head("coll_reset_head", 16, 12, 3);
      check_rd("coll_reset_rd2", 2, 14, 12, 1'b1);
   endtask

   task automatic test_back_to_back();
      int extra = 0;
      do_reset();
      do_tick(3'd4, 1'b0, 0, 0);
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      wait_done("b2b_first");
      step();
      for (int i = 0; i < 10; i++) begin
         if (step_done || busy) extra++;
         step();
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL b2b_dropped: extra activity cycles=%0d want 0", extra);
      end
      check_head("b2b_head", 17, 12, 3);
   endtask

   task automatic test_wall();
      do_reset();
      for (int i = 0; i < 15; i++) begin
         do_tick(3'd4, 1'b0, 0, 0);
         wait_done("wall_walk");
      end
      check_head("wall_edge", 31, 12, 3);
      do_tick(3'd4, 1'b0, 0, 0);
`ifdef SNAKE_WRAP_EN
      wait_done("wall_wrap");
      checks++;
      if (over !== 1'b0) begin
         errors++;
         $display("FAIL wall_wrap_over: over=%b want 0", over);
      end
      check_head("wall_wrap_head", 0, 12, 3);
`else
      step();
      checks++;
      if (over !== 1'b1 || step_done !== 1'b1) begin
         errors++;
         $display("FAIL wall_over: over=%b done=%b want 1 1", over, step_done);
      end
      check_head("wall_no_shift", 31, 12, 3);
      check_rd("wall_seg1", 1, 30, 12, 1'b1);
`endif
   endtask

   task automatic test_reset_mid_scan();
      do_reset();
      for (int i = 0; i < 13; i++) begin
         do_tick(3'd4, 1'b1, 17 + i, 12);
         wait_done("fill");
      end
      check_head("full_len", 29, 12, 16);
      do_tick(3'd4, 1'b1, 30, 12);
      wait_done("sat_grow");
      checks++;
      if (eat !== 1'b1) begin
         errors++;
         $display("FAIL sat_eat: eat=%b want 1", eat);
      end
      check_head("sat_len", 30, 12, 16);
      do_tick(3'd4, 1'b0, 0, 0);
      step(5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || over !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: busy=%b over=%b want 0 0", busy, over);
      end
      check_head("abort_head", 16, 12, 3);
      check_rd("abort_rd1", 1, 15, 12, 1'b1);
      check_rd("abort_rd3", 3, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_move();
      test_grow();
      test_collision();
      test_back_to_back();
      test_wall();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
